// File: rtl/msgdma_st_sink.sv
// Avalon-ST sink: buffers mSGDMA MM2S words in a FIFO, drains them into a word counter and checksum, exposes CSRs and an activity LED.
// Optional build macro MSGDMA_ST_SINK_STALL_CNT_EN adds a 24-bit saturating stall counter reported in STATUS[31:8].
module msgdma_st_sink #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] LED_HOLD   = 32'd10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] st_sink_data,
    input  logic        st_sink_valid,
    output logic        st_sink_ready,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        activity_led
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          out_of_reset;
    logic          enable;
    logic [31:0]   word_cnt;
    logic [31:0]   chksum;
    logic [31:0]   hold_cnt;
    logic          push;
    logic          pop;
    logic          ctrl_wr;
    logic          clear;
    logic [31:0]   pop_data;
    logic [31:0]   status;
    logic [31:0]   reg_mux;
    logic          unused_wdata;

    // Ready depends only on registered state, so it is low throughout reset.
    assign st_sink_ready = out_of_reset && (level != FULL_LVL);
    assign push          = st_sink_valid && st_sink_ready;
    assign pop           = enable && (level != '0);
    assign ctrl_wr       = csr_write && (csr_address == 2'd2);
    assign clear         = ctrl_wr && csr_writedata[1];
    assign pop_data      = mem[rd_ptr];
    assign activity_led  = (hold_cnt != '0);
    assign unused_wdata  = &{1'b0, csr_writedata[31:2]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= st_sink_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A clear cancels a coincident pop entirely: not counted, no LED reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_of_reset <= 1'b0;
            enable       <= 1'b0;
            word_cnt     <= '0;
            chksum       <= '0;
            hold_cnt     <= '0;
        end else begin
            out_of_reset <= 1'b1;
            if (ctrl_wr) begin
                enable <= csr_writedata[0];
            end
            if (clear) begin
                word_cnt <= '0;
                chksum   <= '0;
            end else if (pop) begin
                word_cnt <= word_cnt + 32'd1;
                chksum   <= chksum + pop_data;
            end
            if (pop && !clear) begin
                hold_cnt <= LED_HOLD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 32'd1;
            end
        end
    end

`ifdef MSGDMA_ST_SINK_STALL_CNT_EN
    logic [23:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            stall_cnt <= '0;
        end else if (st_sink_valid && !st_sink_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 24'd1;
        end
    end

    assign status = {stall_cnt, 8'(level)};
`else
    assign status = {24'd0, 8'(level)};
`endif

    always_comb begin
        reg_mux = '0;
        case (csr_address)
            2'd0:    reg_mux = word_cnt;
            2'd1:    reg_mux = chksum;
            2'd2:    reg_mux = {31'd0, enable};
            default: reg_mux = status;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_readdata <= '0;
        end else begin
            csr_readdata <= csr_read ? reg_mux : '0;
        end
    end

endmodule

// File: tb/tb_msgdma_st_sink.sv
// Self-checking bench for msgdma_st_sink: directed vector table, corner-case sequences, and a randomized run against a queue-based model.
module tb_msgdma_st_sink;
    localparam int          DEPTH = 16;
    localparam logic [31:0] HOLD  = 32'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] st_sink_data = '0;
    logic        st_sink_valid = 1'b0;
    logic        st_sink_ready;
    logic [1:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        activity_led;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    msgdma_st_sink #(.FIFO_DEPTH(DEPTH), .LED_HOLD(HOLD)) dut (
        .clk(clk),
        .reset(reset),
        .st_sink_data(st_sink_data),
        .st_sink_valid(st_sink_valid),
        .st_sink_ready(st_sink_ready),
        .csr_address(csr_address),
        .csr_read(csr_read),
        .csr_write(csr_write),
        .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata),
        .activity_led(activity_led)
    );

    // Reference model: buffered words as a queue plus the architectural registers.
    logic [31:0] mq[$];
    logic [31:0] m_cnt = '0;
    logic [31:0] m_sum = '0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_rd = '0;
    logic [23:0] m_stall = '0;
    logic        m_en = 1'b0;
    logic        m_live = 1'b0;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] dat;
        logic        rd;
        logic        wr;
        logic [1:0]  adr;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_led;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic vld, input logic [31:0] dat,
                               input logic rd, input logic wr, input logic [1:0] adr,
                               input logic [31:0] wd, input logic e_rdy, input logic e_led,
                               input logic [31:0] e_rd);
        vec_t r;
        r.rst = rst; r.vld = vld; r.dat = dat; r.rd = rd; r.wr = wr; r.adr = adr;
        r.wd = wd; r.e_rdy = e_rdy; r.e_led = e_led; r.e_rd = e_rd;
        return r;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size()) & 32'hFF;
`ifdef MSGDMA_ST_SINK_STALL_CNT_EN
        s[31:8] = m_stall;
`endif
        return s;
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        if (a == 2'd0) return m_cnt;
        if (a == 2'd1) return m_sum;
        if (a == 2'd2) return {31'd0, m_en};
        return m_status();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: predict from the current inputs, advance the DUT, compare outputs to the model.
    task automatic tick();
        logic        m_ready;
        logic        do_push;
        logic        do_pop;
        logic        do_clr;
        logic [31:0] d;
        m_ready = m_live && (mq.size() < DEPTH);
        do_push = st_sink_valid && m_ready;
        do_pop  = m_en && (mq.size() > 0);
        do_clr  = csr_write && (csr_address == 2'd2) && csr_writedata[1];
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_cnt = '0; m_sum = '0; m_hold = '0; m_rd = '0; m_stall = '0;
            m_en = 1'b0; m_live = 1'b0;
        end else begin
            m_rd = csr_read ? m_reg(csr_address) : 32'd0;
            if (do_clr) m_stall = '0;
            else if (st_sink_valid && !m_ready && m_stall != 24'hFFFFFF) m_stall = m_stall + 24'd1;
            if (do_clr) begin
                mq.delete();
                m_cnt = '0;
                m_sum = '0;
                if (m_hold != 0) m_hold = m_hold - 1;
            end else begin
                if (do_pop) begin
                    d = mq.pop_front();
                    m_cnt = m_cnt + 1;
                    m_sum = m_sum + d;
                    m_hold = HOLD;
                end else if (m_hold != 0) begin
                    m_hold = m_hold - 1;
                end
                if (do_push) mq.push_back(st_sink_data);
            end
            if (csr_write && csr_address == 2'd2) m_en = csr_writedata[0];
            m_live = 1'b1;
        end
        check("model_ready", {31'd0, st_sink_ready}, {31'd0, (m_live && mq.size() < DEPTH)});
        check("model_led", {31'd0, activity_led}, {31'd0, (m_hold != 0)});
        check("model_readdata", csr_readdata, m_rd);
    endtask

    task automatic csr_rd(input logic [1:0] a);
        csr_read = 1'b1; csr_address = a;
        tick();
        csr_read = 1'b0;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        tick();
        csr_write = 1'b0;
    endtask

    initial begin
        // rst vld dat rd wr adr wd | rdy led rd
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,            0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,            1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 1,            1, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0,            1, 0, 0));
        tbl.push_back(v(0, 1, 2, 0, 0, 0, 0,            1, 1, 0));
        tbl.push_back(v(0, 1, 3, 0, 0, 0, 0,            1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,            1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            1, 1, 3));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0,            1, 1, 6));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 0,            1, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 3, 0,            1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,            1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h55,       1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 32'h77,       1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 3, 32'hFFFFFFFF, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            1, 0, 3));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0,            1, 0, 6));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 0,            1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 32'h2,        1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0,            1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0,            1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 2, 0,            1, 0, 0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; st_sink_valid = tbl[i].vld; st_sink_data = tbl[i].dat;
            csr_read = tbl[i].rd; csr_write = tbl[i].wr; csr_address = tbl[i].adr;
            csr_writedata = tbl[i].wd;
            tick();
            check($sformatf("tbl_ready[%0d]", i), {31'd0, st_sink_ready}, {31'd0, tbl[i].e_rdy});
            check($sformatf("tbl_led[%0d]", i), {31'd0, activity_led}, {31'd0, tbl[i].e_led});
            check($sformatf("tbl_readdata[%0d]", i), csr_readdata, tbl[i].e_rd);
        end
        st_sink_valid = 1'b0; csr_read = 1'b0; csr_write = 1'b0;

        // Fill with enable=0: 16 words accepted, 4 stalled cycles.
        for (int i = 0; i < 20; i++) begin
            st_sink_valid = 1'b1; st_sink_data = 32'(i);
            tick();
        end
        st_sink_valid = 1'b0;
        check("full_ready", {31'd0, st_sink_ready}, 32'd0);
        csr_rd(2'd3);
        check("full_level", {24'd0, csr_readdata[7:0]}, 32'd16);
`ifdef MSGDMA_ST_SINK_STALL_CNT_EN
        check("stall_cnt", {8'd0, csr_readdata[31:8]}, 32'd4);
`else
        check("status_hi_zero", {8'd0, csr_readdata[31:8]}, 32'd0);
`endif

        // Drain from full: one pop per cycle for 16 cycles.
        csr_wr(2'd2, 32'h1);
        check("drain_start_ready", {31'd0, st_sink_ready}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("drain_ready[%0d]", i), {31'd0, st_sink_ready}, 32'd1);
        end
        csr_rd(2'd0);
        check("drain_cnt_15", csr_readdata, 32'd15);
        csr_rd(2'd0);
        check("drain_cnt_16", csr_readdata, 32'd16);
        csr_rd(2'd1);
        check("drain_sum", csr_readdata, 32'd120);
        csr_rd(2'd3);
        check("drain_level", {24'd0, csr_readdata[7:0]}, 32'd0);
        check("drain_ready_end", {31'd0, st_sink_ready}, 32'd1);

        // Clear coinciding with a pop of 0xFFFFFFFF.
        st_sink_valid = 1'b1; st_sink_data = 32'hFFFFFFFF;
        tick();
        st_sink_valid = 1'b0;
        csr_wr(2'd2, 32'h3);
        csr_rd(2'd0);
        check("clrpop_cnt", csr_readdata, 32'd0);
        csr_rd(2'd1);
        check("clrpop_sum", csr_readdata, 32'd0);
        csr_rd(2'd3);
        check("clrpop_status", csr_readdata, 32'd0);

        // Clear coinciding with a push (also drops enable).
        st_sink_valid = 1'b1; st_sink_data = 32'hAB;
        csr_wr(2'd2, 32'h2);
        st_sink_valid = 1'b0;
        csr_rd(2'd3);
        check("clrpush_level", {24'd0, csr_readdata[7:0]}, 32'd0);
        csr_rd(2'd0);
        check("clrpush_cnt", csr_readdata, 32'd0);

        // Reset mid-stream with 8 words buffered.
        for (int i = 0; i < 8; i++) begin
            st_sink_valid = 1'b1; st_sink_data = 32'(100 + i);
            tick();
        end
        csr_rd(2'd3);
        check("pre_reset_level", {24'd0, csr_readdata[7:0]}, 32'd8);
        reset = 1'b1;
        tick();
        check("rst_ready", {31'd0, st_sink_ready}, 32'd0);
        check("rst_led", {31'd0, activity_led}, 32'd0);
        csr_read = 1'b1; csr_address = 2'd3;
        tick();
        csr_read = 1'b0;
        check("rst_readdata", csr_readdata, 32'd0);
        check("rst_ready2", {31'd0, st_sink_ready}, 32'd0);
        reset = 1'b0; st_sink_valid = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, st_sink_ready}, 32'd1);
        csr_wr(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) tick();
        csr_rd(2'd0);
        check("post_rst_cnt", csr_readdata, 32'd0);
        csr_rd(2'd3);
        check("post_rst_level", {24'd0, csr_readdata[7:0]}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            st_sink_valid = ($urandom_range(0, 3) != 0);
            st_sink_data  = $urandom;
            csr_read      = $urandom_range(0, 1) == 1;
            csr_write     = ($urandom_range(0, 11) == 0);
            csr_address   = 2'($urandom_range(0, 3));
            csr_writedata = $urandom & 32'hFFFFFFFD;
            if ($urandom_range(0, 7) == 0) csr_writedata[1] = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
